// File: rtl/lightgun_latch_arbiter.sv
// Light-gun hit sequencer: glitch-filters two sensors, arms on VDE rise, grants one
// round-robin hit per frame into a shared H (and optional V, LG_VLATCH_EN) counter latch.
module lightgun_latch_arbiter #(
  parameter int unsigned FILTER  = 3,
  parameter logic [8:0]  HOFFSET = 9'd0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE_PIX,
  input  logic       VDE,
  input  logic [8:0] HCNT,
  input  logic [8:0] VCNT,
  input  logic       SENSOR_A,
  input  logic       SENSOR_B,
  input  logic       EN_A,
  input  logic       EN_B,
  input  logic       RD_ACK,
  output logic       TH_N_A,
  output logic       TH_N_B,
  output logic [7:0] HLATCH,
  output logic [8:0] VLATCH,
  output logic       LATCH_VALID,
  output logic       LATCH_SRC
);

  localparam int unsigned CNT_W       = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
  localparam int unsigned FILT_LAST_I = (FILTER == 0) ? 0 : FILTER - 1;
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_LAST_I);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LATCHED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       filt_prev_q;
  logic [1:0]       th_n_q;
  logic             vde_q;
  logic             rr_q, rr_d;
  logic [7:0]       hlatch_q, hlatch_d;
  logic             valid_q, valid_d;
  logic             src_q, src_d;

  logic [1:0] raw;
  logic [1:0] en;
  logic [1:0] hit;
  logic       vde_rise;
  logic       capture;
  logic       win_b;
  logic [8:0] hsum;
  logic       unused_hbit;

  assign raw         = {SENSOR_B, SENSOR_A};
  assign en          = {EN_B, EN_A};
  assign vde_rise    = VDE & ~vde_q;
  assign hit         = filt_q & ~filt_prev_q & en & {2{VDE}};
  assign hsum        = 9'(HCNT + HOFFSET);
  assign unused_hbit = hsum[0];

  // Per-port persistence filter; the counter clamps at the switch point
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = cnt_q[i];
      if (FILTER == 0) begin
        filt_d[i] = raw[i];
        cnt_d[i]  = '0;
      end else if (CE_PIX) begin
        if (raw[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= FILT_LAST) begin
          filt_d[i] = raw[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Arming / grant / latch next-state
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    hlatch_d = hlatch_q;
    src_d    = src_q;
    valid_d  = valid_q;
    capture  = 1'b0;
    win_b    = 1'b0;

    if (RD_ACK) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (vde_rise) state_d = ARMED;
      end
      ARMED: begin
        if (|hit) begin
          capture = 1'b1;
          state_d = LATCHED;
          win_b   = (&hit) ? rr_q : hit[1];
          rr_d    = ~win_b;
        end
      end
      LATCHED: begin
        if (vde_rise) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase

    if (!(EN_A | EN_B)) state_d = IDLE;

    if (capture) begin
      hlatch_d = hsum[8:1];
      src_d    = win_b;
      valid_d  = 1'b1;
    end
  end

  // vde_q resets high so a VDE already high at release is not taken as an edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      filt_q      <= 2'b00;
      filt_prev_q <= 2'b00;
      th_n_q      <= 2'b11;
      vde_q       <= 1'b1;
      rr_q        <= 1'b0;
      hlatch_q    <= 8'h00;
      valid_q     <= 1'b0;
      src_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      th_n_q      <= ~filt_q;
      vde_q       <= VDE;
      rr_q        <= rr_d;
      hlatch_q    <= hlatch_d;
      valid_q     <= valid_d;
      src_q       <= src_d;
    end
  end

`ifdef LG_VLATCH_EN
  logic [8:0] vlatch_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vlatch_q <= 9'h000;
    end else if (capture) begin
      vlatch_q <= VCNT;
    end
  end

  assign VLATCH = vlatch_q;
`else
  logic unused_vcnt;

  assign unused_vcnt = ^VCNT;
  assign VLATCH      = 9'h000;
`endif

  assign TH_N_A      = th_n_q[0];
  assign TH_N_B      = th_n_q[1];
  assign HLATCH      = hlatch_q;
  assign LATCH_VALID = valid_q;
  assign LATCH_SRC   = src_q;

endmodule

// File: tb/tb_lightgun_latch_arbiter.sv
// Directed bench for lightgun_latch_arbiter (FILTER=3); a second instance uses HOFFSET=20.
module tb_lightgun_latch_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce_pix;
  logic       vde;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       sensor_a, sensor_b;
  logic       en_a, en_b;
  logic       rd_ack;

  logic       th_n_a, th_n_b;
  logic [7:0] hlatch;
  logic [8:0] vlatch;
  logic       valid, src;

  logic       o_th_n_a, o_th_n_b;
  logic [7:0] o_hlatch;
  logic [8:0] o_vlatch;
  logic       o_valid, o_src;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  lightgun_latch_arbiter #(.FILTER(3), .HOFFSET(9'd0)) dut (
    .CLK(clk), .RESET_N(rst_n), .CE_PIX(ce_pix), .VDE(vde), .HCNT(hcnt), .VCNT(vcnt),
    .SENSOR_A(sensor_a), .SENSOR_B(sensor_b), .EN_A(en_a), .EN_B(en_b), .RD_ACK(rd_ack),
    .TH_N_A(th_n_a), .TH_N_B(th_n_b), .HLATCH(hlatch), .VLATCH(vlatch),
    .LATCH_VALID(valid), .LATCH_SRC(src)
  );

  lightgun_latch_arbiter #(.FILTER(3), .HOFFSET(9'd20)) dut_off (
    .CLK(clk), .RESET_N(rst_n), .CE_PIX(ce_pix), .VDE(vde), .HCNT(hcnt), .VCNT(vcnt),
    .SENSOR_A(sensor_a), .SENSOR_B(sensor_b), .EN_A(en_a), .EN_B(en_b), .RD_ACK(rd_ack),
    .TH_N_A(o_th_n_a), .TH_N_B(o_th_n_b), .HLATCH(o_hlatch), .VLATCH(o_vlatch),
    .LATCH_VALID(o_valid), .LATCH_SRC(o_src)
  );

  // Advance one clock; CE_PIX runs at half rate
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      ce_pix = (cyc % 2 == 1);
    end
  endtask

  task automatic frame_start();
    vde = 1'b0;
    step(3);
    vde = 1'b1;
    step(3);
  endtask

  task automatic pulse(input logic a, input logic b, input logic [8:0] h);
    hcnt     = h;
    sensor_a = a;
    sensor_b = b;
    step(12);
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    step(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    checks++; if (th_n_a !== 1'b1) begin errors++; $display("FAIL reset_th_n_a: got %b expected 1", th_n_a); end
    checks++; if (th_n_b !== 1'b1) begin errors++; $display("FAIL reset_th_n_b: got %b expected 1", th_n_b); end
    checks++; if (hlatch !== 8'h00) begin errors++; $display("FAIL reset_hlatch: got %0d expected 0", hlatch); end
    checks++; if (vlatch !== 9'h000) begin errors++; $display("FAIL reset_vlatch: got %0d expected 0", vlatch); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (src !== 1'b0) begin errors++; $display("FAIL reset_src: got %b expected 0", src); end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_glitch();
    logic saw_low;
    saw_low = 1'b0;
    en_a = 1'b1;
    frame_start();
    hcnt     = 9'd100;
    sensor_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (th_n_a !== 1'b1) saw_low = 1'b1;
    end
    sensor_a = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (th_n_a !== 1'b1) saw_low = 1'b1;
    end
    checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL glitch_th_n: got low=%b expected 0", saw_low); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", valid); end
  endtask

  task automatic test_basic();
    hcnt     = 9'd100;
    sensor_a = 1'b1;
    step(12);
    checks++; if (th_n_a !== 1'b0) begin errors++; $display("FAIL basic_th_n_a: got %b expected 0", th_n_a); end
    checks++; if (hlatch !== 8'd50) begin errors++; $display("FAIL basic_hlatch: got %0d expected 50", hlatch); end
    checks++; if (src !== 1'b0) begin errors++; $display("FAIL basic_src: got %b expected 0", src); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid); end
    checks++; if (th_n_b !== 1'b1) begin errors++; $display("FAIL basic_th_n_b: got %b expected 1", th_n_b); end
    sensor_a = 1'b0;
    step(12);
    checks++; if (th_n_a !== 1'b1) begin errors++; $display("FAIL basic_th_n_a_release: got %b expected 1", th_n_a); end
  endtask

  task automatic test_lockout();
    pulse(1'b1, 1'b0, 9'd200);
    checks++; if (hlatch !== 8'd50) begin errors++; $display("FAIL lockout_hlatch: got %0d expected 50", hlatch); end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected 0", valid); end
    pulse(1'b1, 1'b0, 9'd220);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ack_still_latched: got %b expected 0", valid); end
    frame_start();
    pulse(1'b1, 1'b0, 9'd200);
    checks++; if (hlatch !== 8'd100) begin errors++; $display("FAIL rearm_hlatch: got %0d expected 100", hlatch); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rearm_valid: got %b expected 1", valid); end
  endtask

  task automatic test_both();
    en_b = 1'b1;
    frame_start();
    pulse(1'b0, 1'b1, 9'd300);
    checks++; if (src !== 1'b1) begin errors++; $display("FAIL b_only_src: got %b expected 1", src); end
    checks++; if (hlatch !== 8'd150) begin errors++; $display("FAIL b_only_hlatch: got %0d expected 150", hlatch); end
    frame_start();
    pulse(1'b1, 1'b1, 9'd120);
    checks++; if (src !== 1'b0) begin errors++; $display("FAIL both1_src: got %b expected 0", src); end
    checks++; if (hlatch !== 8'd60) begin errors++; $display("FAIL both1_hlatch: got %0d expected 60", hlatch); end
    frame_start();
    pulse(1'b1, 1'b1, 9'd140);
    checks++; if (src !== 1'b1) begin errors++; $display("FAIL both2_src: got %b expected 1", src); end
    checks++; if (hlatch !== 8'd70) begin errors++; $display("FAIL both2_hlatch: got %0d expected 70", hlatch); end
  endtask

  task automatic test_hoffset();
    logic [8:0] exp_v;
`ifdef LG_VLATCH_EN
    exp_v = 9'd150;
`else
    exp_v = 9'd0;
`endif
    frame_start();
    vcnt = 9'd150;
    pulse(1'b1, 1'b0, 9'd500);
    checks++; if (o_hlatch !== 8'd4) begin errors++; $display("FAIL hoffset_hlatch: got %0d expected 4", o_hlatch); end
    checks++; if (hlatch !== 8'd250) begin errors++; $display("FAIL nooffset_hlatch: got %0d expected 250", hlatch); end
    checks++; if (o_src !== 1'b0) begin errors++; $display("FAIL hoffset_src: got %b expected 0", o_src); end
    checks++; if (vlatch !== exp_v) begin errors++; $display("FAIL vlatch: got %0d expected %0d", vlatch, exp_v); end
    vcnt = 9'd0;
  endtask

  task automatic test_ack_capture();
    int waited;
    frame_start();
    rd_ack   = 1'b1;
    hcnt     = 9'd60;
    sensor_a = 1'b1;
    waited   = 0;
    step();
    while (th_n_a !== 1'b0 && waited < 20) begin
      step();
      waited++;
    end
    checks++; if (th_n_a !== 1'b0) begin errors++; $display("FAIL ack_cap_timeout: th_n_a got %b expected 0", th_n_a); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ack_cap_valid: got %b expected 1", valid); end
    checks++; if (hlatch !== 8'd30) begin errors++; $display("FAIL ack_cap_hlatch: got %0d expected 30", hlatch); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ack_after_cap: got %b expected 0", valid); end
    rd_ack   = 1'b0;
    sensor_a = 1'b0;
    step(12);
  endtask

  task automatic test_disable();
    frame_start();
    en_a = 1'b0;
    en_b = 1'b0;
    step(2);
    en_a = 1'b1;
    pulse(1'b1, 1'b0, 9'd80);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL disable_valid: got %b expected 0", valid); end
    checks++; if (hlatch !== 8'd30) begin errors++; $display("FAIL disable_hlatch_held: got %0d expected 30", hlatch); end
    frame_start();
    pulse(1'b1, 1'b0, 9'd80);
    checks++; if (hlatch !== 8'd40) begin errors++; $display("FAIL reenable_hlatch: got %0d expected 40", hlatch); end
  endtask

  task automatic test_reset_mid();
    hcnt     = 9'd100;
    sensor_a = 1'b1;
    step(12);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (th_n_a !== 1'b1) begin errors++; $display("FAIL midrst_th_n_a: got %b expected 1", th_n_a); end
    checks++; if (hlatch !== 8'h00) begin errors++; $display("FAIL midrst_hlatch: got %0d expected 0", hlatch); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", valid); end
    checks++; if (src !== 1'b0) begin errors++; $display("FAIL midrst_src: got %b expected 0", src); end
    sensor_a = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    pulse(1'b1, 1'b0, 9'd100);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL postrst_valid: got %b expected 0", valid); end
    checks++; if (hlatch !== 8'h00) begin errors++; $display("FAIL postrst_hlatch: got %0d expected 0", hlatch); end
    frame_start();
    pulse(1'b1, 1'b0, 9'd100);
    checks++; if (hlatch !== 8'd50) begin errors++; $display("FAIL postrst_rearm_hlatch: got %0d expected 50", hlatch); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL postrst_rearm_valid: got %b expected 1", valid); end
  endtask

  initial begin
    rst_n    = 1'b0;
    ce_pix   = 1'b0;
    vde      = 1'b0;
    hcnt     = 9'd0;
    vcnt     = 9'd0;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    en_a     = 1'b0;
    en_b     = 1'b0;
    rd_ack   = 1'b0;

    test_reset();
    test_glitch();
    test_basic();
    test_lockout();
    test_both();
    test_hoffset();
    test_ack_capture();
    test_disable();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lightgun_latch_arbiter.md
# lightgun_latch_arbiter

Sequences light-gun sensor hits into the VDP horizontal-counter latch and shares that single latch between the two controller ports. It sits between the two light-gun sensor outputs and the VDP H-counter read path. Each sensor is glitch-filtered, and each frame is armed at active-video start. At most one hit per frame is granted, with round-robin priority between ports. The captured H count (and optionally V count) is held for the CPU until acknowledged.

## Interface
- FILTER, 3: consecutive CE_PIX ticks a raw sensor level must persist before the filtered level follows; 0 = bypass (one CLK register only).
- HOFFSET, 9'd0: added to HCNT (mod 512) before latching, compensating sensor pipeline delay.
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CE_PIX  in  1  pixel clock enable.
- VDE  in  1  vertical display enable; the rising edge arms a frame.
- HCNT  in  9  VDP pixel counter.
- VCNT  in  9  VDP line counter.
- SENSOR_A, SENSOR_B  in  1  raw light-gun sensor outputs, high = light seen.
- EN_A, EN_B  in  1  port configured as light gun.
- RD_ACK  in  1  one-CLK pulse; CPU has read the latch.
- TH_N_A, TH_N_B  out  1  filtered sensor as TH pin level, low = light.
- HLATCH  out  8  latched (HCNT+HOFFSET)[8:1].
- VLATCH  out  9  latched VCNT (see Configuration).
- LATCH_VALID  out  1  a latch is pending CPU read.
- LATCH_SRC  out  1  0 = port A, 1 = port B granted.

## Operation
- Reset values:
  - State IDLE.
  - TH_N_A=TH_N_B=1.
  - HLATCH=8'h00, VLATCH=9'h000.
  - LATCH_VALID=0, LATCH_SRC=0.
  - Round-robin pointer rr=0 (A first).
  - Filter counters=0, filtered levels=0.
- Filter, per port:
  - On CE_PIX, if the raw level ≠ the filtered level, increment the counter. Otherwise clear it.
  - When the counter reaches FILTER, the filtered level takes the raw level and the counter clears.
  - The counter saturates and never wraps.
  - TH_N_x = ~filtered_x, independent of EN_x.
- A hit on port x is a filtered 0→1 transition with EN_x=1 and VDE=1.
- States:
  - IDLE: on VDE rising edge with (EN_A|EN_B) → ARMED.
  - ARMED, a single hit: capture HLATCH=(HCNT+HOFFSET)[8:1] using the HCNT value in the hit cycle, set LATCH_SRC=port and LATCH_VALID=1 → LATCHED. rr points to the other port.
  - ARMED, hits on both ports in the same cycle: port rr wins and the loser is dropped (no queue). rr toggles.
  - LATCHED: all hits ignored. On VDE rising edge → ARMED. LATCH_VALID is not cleared by re-arming.
  - Any state: EN_A=EN_B=0 → IDLE next CLK. HLATCH, VLATCH, LATCH_VALID and LATCH_SRC are held.
- RD_ACK clears LATCH_VALID and does not change state.
  - RD_ACK coinciding with a capture: capture wins, LATCH_VALID=1 with new data.
  - A new capture while LATCH_VALID=1 overwrites HLATCH, VLATCH and LATCH_SRC.
- HCNT+HOFFSET wraps mod 512, and bit 0 is discarded.
- Reset asserted mid-frame returns immediately to the reset values. The block is not armed until the next full VDE rising edge after release.

## Timing
- Raw sensor change to TH_N_x change: FILTER CE_PIX ticks + 1 CLK. With FILTER=0: 1 CLK.
- Filtered rising edge detection is registered. HLATCH and LATCH_VALID update 1 CLK after the filtered level rises.
- The VDE edge detector samples every CLK. The state moves to ARMED 1 CLK after the rising edge.
- RD_ACK clears LATCH_VALID on the next CLK edge.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Configuration
- LG_VLATCH_EN defined: VLATCH captures VCNT in the same cycle as HLATCH.
- LG_VLATCH_EN undefined:
  - The VLATCH port still exists and is tied to 9'h000.
  - No V capture registers are synthesized.
  - All other behaviour is identical.

## Test plan
- FILTER=3, HOFFSET=0, EN_A=1:
  - Stimulus: VDE rises, then SENSOR_A goes high for ≥4 CE_PIX while HCNT=9'd100.
  - Required: TH_N_A=0, HLATCH=8'd50, LATCH_SRC=0, LATCH_VALID=1.
- Glitch rejection:
  - Stimulus: SENSOR_A high for 2 CE_PIX only with FILTER=3.
  - Required: TH_N_A stays 1 and there is no capture.
- Both enabled, rr=0, filtered A and B rise in the same cycle:
  - Required first frame: LATCH_SRC=0.
  - Required after the next VDE rise with both hitting again: LATCH_SRC=1.
- Lockout:
  - Stimulus: a second hit in the same frame at HCNT=200 after the first at HCNT=100.
  - Required: HLATCH stays 50.
  - Required: after the next VDE rise, a hit at 200 gives HLATCH=100.
- HOFFSET=9'd20, hit at HCNT=500:
  - Required: HLATCH=8'd4 (520 mod 512 = 8, >>1 = 4).
  - Required with LG_VLATCH_EN and VCNT=150: VLATCH=150.
- RD_ACK and capture in the same CLK:
  - Required: LATCH_VALID=1.
- RESET_N low mid-LATCHED:
  - Required: all outputs return to their reset values at once.
  - Required: hits before the next VDE rise are ignored.
